// File: rtl/clock_pkg.sv
// Shared definitions for the alarm-clock time chain: set-mode state
// encoding, field terminal counts, field widths and the day-value
// saturation helper used by the day-counter parallel load.
package clock_pkg;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_SET_MIN  = 2'd1,
        ST_SET_HOUR = 2'd2,
        ST_SET_DAY  = 2'd3
    } state_e;

    localparam int unsigned SEC_MAX = 59;
    localparam int unsigned DAY_MAX = 6;

    localparam int unsigned SEC_W  = 6;
    localparam int unsigned MIN_W  = 6;
    localparam int unsigned HOUR_W = 5;
    localparam int unsigned DAY_W  = 3;

    // Day values above DAY_MAX (only 7 fits in DAY_W bits) clamp to DAY_MAX.
    function automatic logic [DAY_W-1:0] sat_day(input logic [DAY_W-1:0] d);
        return (d > DAY_W'(DAY_MAX)) ? DAY_W'(DAY_MAX) : d;
    endfunction

endpackage

// File: rtl/set_timeout.sv
// Set-mode inactivity timer. Counts ticks while not cleared and raises a
// combinational expire pulse on the tick that brings the count to
// TIMEOUT_S; the counter then restarts from zero.
//   clk_i     system clock, rising edge
//   rst_i     asynchronous active-high reset
//   tick_i    1 Hz tick pulse
//   clear_i   hold/clear the count (button activity, state change, RUN)
//   expire_o  one-cycle pulse, same cycle as the terminal tick
module set_timeout
    import clock_pkg::*;
#(
    parameter int unsigned TIMEOUT_S = 30
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic tick_i,
    input  logic clear_i,
    output logic expire_o
);

    logic [5:0] cnt_q, cnt_d;
    logic       count_en;

    always_comb begin
        // A clear in the same cycle as a tick swallows that tick.
        count_en = tick_i && !clear_i;
        expire_o = count_en && (cnt_q == 6'(TIMEOUT_S - 1));
        cnt_d    = cnt_q;
        if (clear_i || expire_o) begin
            cnt_d = '0;
        end else if (count_en) begin
            cnt_d = cnt_q + 6'd1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/time_chain_ctrl.sv
// Time-chain sequencer: keeps the seconds count, issues registered
// one-cycle Enable/Up strobes to the external minute/hour/day counters,
// runs the Mode/Inc set-mode FSM with inactivity timeout, and drives the
// day counter's parallel load.
//   Clk, Clr          clock / async active-high reset
//   Tick              1 Hz pulse
//   Mode, Inc         debounced button pulses
//   Preset,Preset_Day day-counter load request and value
//   Min_Val,Hour_Val  external counter feedback for carry detection
//   Min_En,Hour_En,Day_En  counter enable+up strobes
//   Day_Ld, Day_D     day-counter load strobe and data
//   Sec               seconds 0..59
//   Set_State         0=RUN 1=SET_MIN 2=SET_HOUR 3=SET_DAY
//   Blink             display blink phase
module time_chain_ctrl
    import clock_pkg::*;
#(
    parameter int unsigned TIMEOUT_S = 30,
    parameter int unsigned MIN_MAX   = 59,
    parameter int unsigned HOUR_MAX  = 23
) (
    input  logic              Clk,
    input  logic              Clr,
    input  logic              Tick,
    input  logic              Mode,
    input  logic              Inc,
    input  logic              Preset,
    input  logic [DAY_W-1:0]  Preset_Day,
    input  logic [MIN_W-1:0]  Min_Val,
    input  logic [HOUR_W-1:0] Hour_Val,
    output logic              Min_En,
    output logic              Hour_En,
    output logic              Day_En,
    output logic              Day_Ld,
    output logic [DAY_W-1:0]  Day_D,
    output logic [SEC_W-1:0]  Sec,
    output logic [1:0]        Set_State,
    output logic              Blink
);

    state_e             state_q, state_d;
    logic [SEC_W-1:0]   sec_q, sec_d;
    logic               blink_q, blink_d;
    logic               min_en_q, min_en_d;
    logic               hour_en_q, hour_en_d;
    logic               day_en_q, day_en_d;
    logic               day_ld_q, day_ld_d;
    logic [DAY_W-1:0]   day_d_q, day_d_d;
    logic               to_clear;
    logic               to_expire;
    logic               in_set;

    set_timeout #(
        .TIMEOUT_S(TIMEOUT_S)
    ) u_set_timeout (
        .clk_i   (Clk),
        .rst_i   (Clr),
        .tick_i  (Tick),
        .clear_i (to_clear),
        .expire_o(to_expire)
    );

    always_comb begin
        state_d   = state_q;
        sec_d     = sec_q;
        blink_d   = blink_q;
        min_en_d  = 1'b0;
        hour_en_d = 1'b0;
        day_en_d  = 1'b0;
        day_ld_d  = 1'b0;
        day_d_d   = day_d_q;
        to_clear  = 1'b0;
        in_set    = (state_q != ST_RUN);

        if (Mode) begin
            // Mode beats Inc (and a coincident Tick in RUN: entering
            // SET_MIN zeroes Sec, so that tick has nothing to advance).
            to_clear = 1'b1;
            unique case (state_q)
                ST_RUN: begin
                    state_d = ST_SET_MIN;
                    sec_d   = '0;
                end
                ST_SET_MIN:  state_d = ST_SET_HOUR;
                ST_SET_HOUR: state_d = ST_SET_DAY;
                ST_SET_DAY:  state_d = ST_RUN;
                default:     state_d = ST_RUN;
            endcase
        end else if (!in_set) begin
            to_clear = 1'b1;
            if (Tick) begin
                if (sec_q == SEC_W'(SEC_MAX)) begin
                    sec_d    = '0;
                    min_en_d = 1'b1;
                    if (Min_Val == MIN_W'(MIN_MAX)) begin
                        hour_en_d = 1'b1;
                        if (Hour_Val == HOUR_W'(HOUR_MAX)) begin
                            day_en_d = 1'b1;
                        end
                    end
                end else begin
                    sec_d = sec_q + SEC_W'(1);
                end
            end
        end else if (Inc) begin
            to_clear = 1'b1;
            unique case (state_q)
                ST_SET_MIN:  min_en_d  = 1'b1;
                ST_SET_HOUR: hour_en_d = 1'b1;
                ST_SET_DAY:  day_en_d  = 1'b1;
                default: ;
            endcase
        end else if (to_expire) begin
            state_d = ST_RUN;
        end

        // Blink only runs while staying inside the set states.
        if (state_d == ST_RUN) begin
            blink_d = 1'b0;
        end else if (in_set && Tick) begin
            blink_d = ~blink_q;
        end

        if (Preset) begin
            day_ld_d = 1'b1;
            day_en_d = 1'b0;
            day_d_d  = sat_day(Preset_Day);
        end
    end

    always_ff @(posedge Clk or posedge Clr) begin
        if (Clr) begin
            state_q   <= ST_RUN;
            sec_q     <= '0;
            blink_q   <= 1'b0;
            min_en_q  <= 1'b0;
            hour_en_q <= 1'b0;
            day_en_q  <= 1'b0;
            day_ld_q  <= 1'b0;
            day_d_q   <= '0;
        end else begin
            state_q   <= state_d;
            sec_q     <= sec_d;
            blink_q   <= blink_d;
            min_en_q  <= min_en_d;
            hour_en_q <= hour_en_d;
            day_en_q  <= day_en_d;
            day_ld_q  <= day_ld_d;
            day_d_q   <= day_d_d;
        end
    end

    assign Min_En    = min_en_q;
    assign Hour_En   = hour_en_q;
    assign Day_En    = day_en_q;
    assign Day_Ld    = day_ld_q;
    assign Day_D     = day_d_q;
    assign Sec       = sec_q;
    assign Set_State = state_q;
    assign Blink     = blink_q;

endmodule
